// File: rtl/vga_pic.sv
// vga_pic: registered RGB888 test-pattern generator for an 800x480 video pipeline
//   clk            pixel clock, all state on rising edge
//   rstn           asynchronous active-low reset
//   keyin[3:0]     one-hot pattern select: 0 vbars, 1 hbars, 2 checker, 3 gradient
//   pix_x, pix_y   current pixel coordinate from the timing generator
//   color_data_out registered colour {R, G, B}, one cycle after the coordinate
module vga_pic #(
   parameter int H_VALID = 800,
   parameter int V_VALID = 480,
   parameter int BAR_W   = 100,
   parameter int BAR_H   = 60,
   parameter int CELL    = 40
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [3:0]  keyin,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   output logic [23:0] color_data_out
);
   localparam logic [3:0] VBARS   = 4'b0001;
   localparam logic [3:0] HBARS   = 4'b0010;
   localparam logic [3:0] CHECKER = 4'b0100;
   localparam logic [23:0] PAL [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
   logic [3:0]  mode;
   logic [2:0]  vi, hi;
   logic        cpar;
   logic [23:0] nxt;
   // only a clean one-hot key changes the pattern; idle or chorded keys are ignored
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) mode <= VBARS;
      else if (keyin != '0 && (keyin & (keyin - 4'd1)) == '0) mode <= keyin;
   // divisions as threshold compares; checker only needs the parity of cx+cy,
   // which is the xor of every cell boundary already crossed on each axis
   always_comb begin
      vi = '0;
      hi = '0;
      cpar = 1'b0;
      for (int i = 1; i < 8; i++) begin
         if (pix_x >= 10'(i * BAR_W)) vi = 3'(i);
         if (pix_y >= 10'(i * BAR_H)) hi = 3'(i);
      end
      for (int i = 1; i * CELL < H_VALID; i++) cpar ^= (pix_x >= 10'(i * CELL));
      for (int i = 1; i * CELL < V_VALID; i++) cpar ^= (pix_y >= 10'(i * CELL));
      nxt = (pix_x >= 10'(H_VALID) || pix_y >= 10'(V_VALID)) ? 24'h000000 :
            mode == VBARS   ? PAL[vi] :
            mode == HBARS   ? PAL[hi] :
            mode == CHECKER ? (cpar ? 24'h000000 : 24'hFFFFFF) :
                              {pix_x[9:2], pix_y[8:1], 8'h80};
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) color_data_out <= '0;
      else color_data_out <= nxt;
endmodule

// File: tb/tb_vga_pic.sv
// tb_vga_pic: directed self-checking bench for vga_pic
module tb_vga_pic;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [3:0]  keyin = 4'b0001;
   logic [9:0]  pix_x = '0;
   logic [9:0]  pix_y = '0;
   logic [23:0] color_data_out;
   int vectors = 0;
   int miscompares = 0;
   logic [23:0] pal [8];

   vga_pic dut (
      .clk(clk),
      .rstn(rstn),
      .keyin(keyin),
      .pix_x(pix_x),
      .pix_y(pix_y),
      .color_data_out(color_data_out)
   );

   always #5 clk = ~clk;

   task automatic drive(input int x, input int y);
      pix_x = 10'(x);
      pix_y = 10'(y);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      keyin = 4'b0001;
      drive(0, 0);
      drive(0, 0);
      vectors++;
      if (color_data_out !== 24'h000000) begin
         miscompares++;
         $display("FAIL reset_out: got %h want 000000", color_data_out);
      end
      rstn = 1'b1;
      drive(0, 0);
      vectors++;
      if (color_data_out !== 24'hFFFFFF) begin
         miscompares++;
         $display("FAIL reset_release: got %h want FFFFFF", color_data_out);
      end
   endtask

   task automatic test_vbars;
      logic [23:0] want;
      keyin = 4'b0001;
      for (int x = 0; x < 800; x++) begin
         drive(x, 10);
         want = pal[x / 100];
         vectors++;
         if (color_data_out !== want) begin
            miscompares++;
            $display("FAIL vbars x=%0d: got %h want %h", x, color_data_out, want);
         end
      end
      drive(99, 10);
      vectors++;
      if (color_data_out !== 24'hFFFFFF) begin miscompares++; $display("FAIL vbars_99: got %h want FFFFFF", color_data_out); end
      drive(100, 10);
      vectors++;
      if (color_data_out !== 24'hFFFF00) begin miscompares++; $display("FAIL vbars_100: got %h want FFFF00", color_data_out); end
      drive(450, 10);
      vectors++;
      if (color_data_out !== 24'hFF00FF) begin miscompares++; $display("FAIL vbars_450: got %h want FF00FF", color_data_out); end
      drive(799, 10);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL vbars_799: got %h want 000000", color_data_out); end
   endtask

   task automatic test_hbars;
      keyin = 4'b0010;
      drive(5, 0);
      drive(5, 59);
      vectors++;
      if (color_data_out !== 24'hFFFFFF) begin miscompares++; $display("FAIL hbars_59: got %h want FFFFFF", color_data_out); end
      drive(5, 60);
      vectors++;
      if (color_data_out !== 24'hFFFF00) begin miscompares++; $display("FAIL hbars_60: got %h want FFFF00", color_data_out); end
      drive(5, 300);
      vectors++;
      if (color_data_out !== 24'hFF0000) begin miscompares++; $display("FAIL hbars_300: got %h want FF0000", color_data_out); end
      drive(5, 479);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL hbars_479: got %h want 000000", color_data_out); end
   endtask

   task automatic test_checker_switch;
      keyin = 4'b0001;
      drive(40, 0);
      drive(40, 0);
      keyin = 4'b0100;
      drive(40, 0);
      vectors++;
      if (color_data_out !== 24'hFFFFFF) begin miscompares++; $display("FAIL chk_latency1: got %h want FFFFFF", color_data_out); end
      drive(40, 0);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL chk_latency2: got %h want 000000", color_data_out); end
      drive(0, 0);
      vectors++;
      if (color_data_out !== 24'hFFFFFF) begin miscompares++; $display("FAIL chk_0_0: got %h want FFFFFF", color_data_out); end
      drive(39, 0);
      vectors++;
      if (color_data_out !== 24'hFFFFFF) begin miscompares++; $display("FAIL chk_39_0: got %h want FFFFFF", color_data_out); end
      drive(40, 40);
      vectors++;
      if (color_data_out !== 24'hFFFFFF) begin miscompares++; $display("FAIL chk_40_40: got %h want FFFFFF", color_data_out); end
      drive(0, 40);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL chk_0_40: got %h want 000000", color_data_out); end
      drive(799, 479);
      vectors++;
      if (color_data_out !== 24'hFFFFFF) begin miscompares++; $display("FAIL chk_799_479: got %h want FFFFFF", color_data_out); end
   endtask

   task automatic test_invalid_key;
      keyin = 4'b0000;
      drive(40, 0);
      drive(40, 0);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL key_0000: got %h want 000000", color_data_out); end
      keyin = 4'b0110;
      drive(40, 0);
      drive(40, 0);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL key_0110: got %h want 000000", color_data_out); end
      drive(800, 0);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL oor_x800: got %h want 000000", color_data_out); end
      drive(0, 480);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL oor_y480: got %h want 000000", color_data_out); end
   endtask

   task automatic test_gradient;
      keyin = 4'b1000;
      drive(0, 0);
      drive(400, 200);
      vectors++;
      if (color_data_out !== 24'h646480) begin miscompares++; $display("FAIL grad_400_200: got %h want 646480", color_data_out); end
      drive(799, 479);
      vectors++;
      if (color_data_out !== 24'hC7EF80) begin miscompares++; $display("FAIL grad_799_479: got %h want C7EF80", color_data_out); end
      drive(800, 10);
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL grad_oor: got %h want 000000", color_data_out); end
   endtask

   task automatic test_async_reset;
      drive(400, 200);
      #2;
      rstn = 1'b0;
      #1;
      vectors++;
      if (color_data_out !== 24'h000000) begin miscompares++; $display("FAIL async_reset: got %h want 000000", color_data_out); end
      keyin = 4'b0000;
      @(negedge clk);
      rstn = 1'b1;
      drive(150, 0);
      vectors++;
      if (color_data_out !== 24'hFFFF00) begin miscompares++; $display("FAIL reset_mode: got %h want FFFF00", color_data_out); end
   endtask

   initial begin
      pal = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      test_reset;
      test_vbars;
      test_hbars;
      test_checker_switch;
      test_invalid_key;
      test_gradient;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
